// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma output path: ternary codes, bridge
// FSM states and the H-bridge gate vectors, ordered {AH, AL, BH, BL}.
package dsm_pkg;

    localparam logic [1:0] CODE_ZERO = 2'b00;
    localparam logic [1:0] CODE_POS  = 2'b01;
    localparam logic [1:0] CODE_INV  = 2'b10;
    localparam logic [1:0] CODE_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DEAD  = 2'd1,
        ST_DRIVE = 2'd2
    } bridge_state_e;

    localparam logic [3:0] GATES_OFF  = 4'b0000;
    localparam logic [3:0] GATES_POS  = 4'b1001;  // AH + BL
    localparam logic [3:0] GATES_NEG  = 4'b0110;  // AL + BH
    localparam logic [3:0] GATES_ZERO = 4'b0101;  // AL + BL, low-side freewheel

    function automatic logic [1:0] sanitize_code(input logic [1:0] code);
        return (code == CODE_INV) ? CODE_ZERO : code;
    endfunction

    function automatic logic [3:0] gate_vec(input logic [1:0] code);
        case (code)
            CODE_POS: return GATES_POS;
            CODE_NEG: return GATES_NEG;
            default:  return GATES_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous clear has priority.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (clr_i)
            count_q <= '0;
        else if (inc_i && (count_q != {W{1'b1}}))
            count_q <= count_q + W'(1);
    end

    assign count_o = count_q;

endmodule

// File: rtl/hbridge_deadtime.sv
// H-bridge gate driver for the ternary modulator code: dead-time insertion on
// every level change, sticky fault shutdown and an illegal-code counter.
module hbridge_deadtime
    import dsm_pkg::*;
#(
    parameter int DEAD_CYCLES = 4,
    parameter int CNT_W       = 8,
    parameter int ERR_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             fault,
    input  logic [1:0]       pwm_code,
    output logic             gate_ah,
    output logic             gate_al,
    output logic             gate_bh,
    output logic             gate_bl,
    output logic [1:0]       applied_code,
    output logic             busy,
    output logic             fault_latched,
    output logic [ERR_W-1:0] invalid_cnt
);

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES);

    bridge_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       applied_q, applied_d;
    logic [3:0]       gates_q, gates_d;
    logic             fault_q, fault_d;
    logic             busy_q;
    logic [1:0]       code_s;

    assign code_s = sanitize_code(pwm_code);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        applied_d = applied_q;
        fault_d   = fault_q | fault;

        if (fault || fault_q || !enable) begin
            state_d   = ST_OFF;
            cnt_d     = '0;
            applied_d = CODE_ZERO;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d   = ST_DEAD;
                    cnt_d     = DEAD_LOAD;
                    applied_d = CODE_ZERO;
                end
                ST_DEAD: begin
                    // Only the code present at the expiry edge is taken.
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d   = ST_DRIVE;
                        cnt_d     = '0;
                        applied_d = code_s;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (code_s != applied_q) begin
                        state_d   = ST_DEAD;
                        cnt_d     = DEAD_LOAD;
                        applied_d = CODE_ZERO;
                    end
                end
                default: begin
                    state_d   = ST_OFF;
                    cnt_d     = '0;
                    applied_d = CODE_ZERO;
                end
            endcase
        end

        // Gates follow the next state so they switch on the same edge.
        gates_d = (state_d == ST_DRIVE) ? gate_vec(applied_d) : GATES_OFF;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            applied_q <= CODE_ZERO;
            gates_q   <= GATES_OFF;
            fault_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            applied_q <= applied_d;
            gates_q   <= gates_d;
            fault_q   <= fault_d;
            busy_q    <= (state_d == ST_DEAD);
        end
    end

    sat_counter #(.W(ERR_W)) u_invalid_cnt (
        .clock   (clock),
        .clr_i   (reset),
        .inc_i   (pwm_code == CODE_INV),
        .count_o (invalid_cnt)
    );

    assign {gate_ah, gate_al, gate_bh, gate_bl} = gates_q;
    assign applied_code  = applied_q;
    assign busy          = busy_q;
    assign fault_latched = fault_q;

endmodule

// File: doc/hbridge_deadtime.md
# hbridge_deadtime

Output stage that consumes the 2-bit ternary code of the delta-sigma modulator (00 = 0, 01 = +1, 11 = −1) and drives the four gates of a full H-bridge. Inserts a programmable all-off dead time on every change of the applied level and latches a fault shutdown. Counts illegal codes. Sits directly downstream of the modulator's registered `pwm` output, on the same clock.

## Interface
- `DEAD_CYCLES`, default 4: all-off cycles inserted on each level change; legal range 1..255.
- `CNT_W`, default 8: dead-time counter width; must hold `DEAD_CYCLES`.
- `ERR_W`, default 16: width of the illegal-code counter.
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `enable`  in  1  bridge enable; low forces all gates off.
- `fault`  in  1  external fault, active-high, sampled every cycle.
- `pwm_code`  in  2  modulator output code.
- `gate_ah`, `gate_al`, `gate_bh`, `gate_bl`  out  1 each  leg A/B high/low-side gate, registered.
- `applied_code`  out  2  code currently driven; 00 while off or in dead time.
- `busy`  out  1  high while in DEAD.
- `fault_latched`  out  1  sticky fault flag.
- `invalid_cnt`  out  ERR_W  saturating count of cycles with `pwm_code` = 10.

## Operation
- Sanitize: code 10 is treated as 00 and counted in `invalid_cnt`.
- Gate map, DRIVE only:
  - 01: AH=1, BL=1.
  - 11: BH=1, AL=1.
  - 00: AL=1, BL=1 (low-side freewheel).
- States:
  - OFF: all gates 0.
  - DEAD: all gates 0, counting.
  - DRIVE: gates per `applied_code`.
- Transitions, evaluated at each rising edge, priority top to bottom:
  - `reset` → OFF, counter 0, all outputs 0, `fault_latched` 0, `invalid_cnt` 0.
  - `fault` = 1 or `fault_latched` = 1 → OFF; set `fault_latched`. It clears only on `reset`.
  - `enable` = 0 → OFF immediately, no dead time.
  - OFF with `enable` = 1 → DEAD; load counter = `DEAD_CYCLES`.
  - DEAD → decrement counter. When the counter reads 1 at the edge, go to DRIVE. `applied_code` = sanitized `pwm_code` sampled at that edge. Codes seen earlier in DEAD are ignored.
  - DRIVE with sanitized `pwm_code` ≠ `applied_code` → DEAD; load `DEAD_CYCLES`; `applied_code` ← 00.
  - DRIVE with equal code → hold.
- Invariants, all cycles:
  - Never AH&AL, never BH&BL.
  - Every change between two non-zero gate vectors passes through ≥ `DEAD_CYCLES` consecutive all-zero cycles.
- `invalid_cnt` increments on every non-reset cycle with `pwm_code` = 10, in any state, and saturates at all-ones.

## Timing
- All outputs are registered. Zero combinational path from input to gate.
- Level change sampled at edge k in DRIVE:
  - Gates are 0 after edges k .. k+DEAD_CYCLES−1.
  - New gate vector appears after edge k+DEAD_CYCLES.
  - Total latency from code change to new drive: `DEAD_CYCLES`+1 cycles.
- A fault sampled at edge k forces gates to 0 and sets `fault_latched` after the same edge k. Fault overrides a concurrent level change or dead-time expiry.
- Enable deassert mid-DEAD → OFF next edge. Re-enable restarts a full dead time.
- `reset` mid-DEAD or mid-DRIVE → OFF at that edge. Dead-time count is discarded.
- `busy` = 1 exactly in DEAD.

## Structure
- Shared `dsm_pkg` holds:
  - Code constants CODE_ZERO=2'b00, CODE_POS=2'b01, CODE_INV=2'b10, CODE_NEG=2'b11.
  - State enum {OFF, DEAD, DRIVE}.
  - Gate-vector constants per code.
- One sub-module, `sat_counter` (parameter W; inputs inc and clr; saturating), instantiated for `invalid_cnt`.
- FSM, dead-time counter and gate register stay in the top module.

## Test plan
- Reset, then `enable`=1, code 01, `DEAD_CYCLES`=4 → gates 0 for 4 cycles, then AH=BL=1, `applied_code`=01, `busy` 1→0.
- In DRIVE 01, switch to 11 → exactly 4 all-zero cycles, then BH=AL=1. Checker asserts no AH&AL or BH&BL in any cycle.
- Toggle the code every cycle during DEAD, ending on 00 at the expiry edge → DRIVE with AL=BL=1, `applied_code`=00.
- Assert `fault` for one cycle while in DRIVE 01 → gates 0 after that edge, `fault_latched`=1, stays OFF with `enable`=1 until `reset`.
- Drive code 10 for 70000 cycles with `ERR_W`=16 → gates AL=BL=1 after dead time, `invalid_cnt` saturates at 16'hFFFF.
- Deassert `enable` mid-DEAD, reassert 2 cycles later → OFF, then a fresh full 4-cycle dead time before drive.
